// File: rtl/stage8_byte_packer.sv
// JPEG-LS output stage: packs variable-length codes MSB-first into bytes, inserting a 0 stuff bit
// after every emitted 0xFF, and pads/terminates the stream on end-of-data.
module stage8_byte_packer #(
  parameter int unsigned dataOut_length      = 32,
  parameter int unsigned encodedlength_width = 6,
  parameter int unsigned acc_width           = 96
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [dataOut_length-1:0]      dataOut,
  input  logic [encodedlength_width-1:0] dataSize,
  input  logic                           dataReady,
  input  logic                           endOfDataStream,
  output logic [7:0]                     byteOut,
  output logic                           byteValid,
  output logic                           almostFull,
  output logic                           overflow,
  output logic                           streamDone
);

  localparam int unsigned CntW = $clog2(acc_width + 1);
  localparam int unsigned SumW = CntW + 1;

  typedef enum logic [1:0] {StRun, StFlush, StDone} state_e;

  state_e                 state_q, state_d;
  logic [acc_width-1:0]   acc_q, acc_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   last_ff_q, last_ff_d;
  logic [7:0]             byte_q, byte_d;
  logic                   valid_q, valid_d;
  logic                   afull_q, afull_d;
  logic                   ovf_q, ovf_d;
  logic                   done_q, done_d;

  logic [CntW-1:0]                need, removed, rem_cnt;
  logic                           emit;
  logic [7:0]                     emit_byte;
  logic [acc_width-1:0]           acc_shift, code_ext;
  logic [encodedlength_width-1:0] size_c;
  logic [dataOut_length-1:0]      code;
  logic [SumW-1:0]                sum;
  logic                           append;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    last_ff_d = last_ff_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    emit      = 1'b0;
    removed   = '0;

    need = last_ff_q ? CntW'(7) : CntW'(8);
    // Bits below the occupancy are kept zero, so the same slice serves full and padded bytes.
    emit_byte = last_ff_q ? {1'b0, acc_q[acc_width-1 -: 7]} : acc_q[acc_width-1 -: 8];

    if (state_q != StDone) begin
      if (cnt_q >= need) begin
        emit    = 1'b1;
        removed = need;
      end else if (state_q == StFlush && (cnt_q != '0 || last_ff_q)) begin
        emit    = 1'b1;
        removed = cnt_q;
      end
    end

    acc_shift = acc_q << removed;
    rem_cnt   = cnt_q - removed;

    size_c = (dataSize > encodedlength_width'(dataOut_length)) ?
             encodedlength_width'(dataOut_length) : dataSize;
    code   = dataOut & ~({dataOut_length{1'b1}} << size_c);
    code_ext = '0;
    code_ext[dataOut_length-1:0] = code;
    sum    = SumW'(rem_cnt) + SumW'(size_c);
    append = (state_q == StRun) && dataReady;

    acc_d = acc_shift;
    cnt_d = rem_cnt;
    if (append) begin
      if (sum > SumW'(acc_width)) begin
        ovf_d = 1'b1;
      end else begin
        acc_d = acc_shift | (code_ext << (SumW'(acc_width) - sum));
        cnt_d = CntW'(sum);
      end
    end

    if (emit) begin
      valid_d   = 1'b1;
      byte_d    = emit_byte;
      last_ff_d = (emit_byte == 8'hFF);
    end

    unique case (state_q)
      StRun: begin
        if (endOfDataStream) state_d = StFlush;
      end
      StFlush: begin
        if (cnt_q == '0 && !last_ff_q) begin
          state_d = StDone;
          done_d  = 1'b1;
        end
      end
      StDone: begin
        state_d   = StRun;
        acc_d     = '0;
        cnt_d     = '0;
        last_ff_d = 1'b0;
      end
      default: state_d = StRun;
    endcase

    afull_d = (cnt_d >= CntW'(acc_width - 32));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StRun;
      acc_q     <= '0;
      cnt_q     <= '0;
      last_ff_q <= 1'b0;
      byte_q    <= 8'h00;
      valid_q   <= 1'b0;
      afull_q   <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      last_ff_q <= last_ff_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      afull_q   <= afull_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign byteOut    = byte_q;
  assign byteValid  = valid_q;
  assign almostFull = afull_q;
  assign overflow   = ovf_q;
  assign streamDone = done_q;

endmodule

// File: tb/tb_stage8_byte_packer.sv
// Bench for stage8_byte_packer: directed vector table, hand-written corner sequences and a
// randomized run checked against a bit-queue reference model.
module tb_stage8_byte_packer;

  logic        clk;
  logic        reset;
  logic [31:0] dataOut;
  logic [5:0]  dataSize;
  logic        dataReady;
  logic        endOfDataStream;
  logic [7:0]  byteOut;
  logic        byteValid;
  logic        almostFull;
  logic        overflow;
  logic        streamDone;

  stage8_byte_packer #(
    .dataOut_length     (32),
    .encodedlength_width(6),
    .acc_width          (96)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .dataOut        (dataOut),
    .dataSize       (dataSize),
    .dataReady      (dataReady),
    .endOfDataStream(endOfDataStream),
    .byteOut        (byteOut),
    .byteValid      (byteValid),
    .almostFull     (almostFull),
    .overflow       (overflow),
    .streamDone     (streamDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: the accumulator is a plain queue of bits, oldest first.
  bit       m_q[$];
  bit       m_lastff;
  int       m_st;      // 0 run, 1 flush, 2 done
  bit       m_bv, m_af, m_ov, m_sd;
  bit [7:0] m_bo;

  function automatic void model_reset();
    m_q.delete();
    m_lastff = 0; m_st = 0;
    m_bv = 0; m_af = 0; m_ov = 0; m_sd = 0; m_bo = 8'h00;
  endfunction

  function automatic void model_step(bit dr, logic [31:0] dout, int dsz, bit eos);
    int  need   = m_lastff ? 7 : 8;
    int  pre_n  = m_q.size();
    bit  pre_ff = m_lastff;
    int  st0    = m_st;
    bit  emit   = 0;
    int  b      = 0;
    m_sd = 0;
    if (st0 != 2) begin
      if (pre_n >= need) begin
        for (int i = 0; i < need; i++) b = (b << 1) | int'(m_q.pop_front());
        emit = 1;
      end else if (st0 == 1 && (pre_n > 0 || pre_ff)) begin
        for (int i = 0; i < pre_n; i++) b = (b << 1) | int'(m_q.pop_front());
        b = b << (need - pre_n);
        emit = 1;
      end
    end
    if (st0 == 0 && dr) begin
      int sz = (dsz > 32) ? 32 : dsz;
      if (m_q.size() + sz > 96) m_ov = 1;
      else for (int i = sz - 1; i >= 0; i--) m_q.push_back(dout[i]);
    end
    if (st0 == 0 && eos) m_st = 1;
    else if (st0 == 1 && pre_n == 0 && !pre_ff) begin
      m_st = 2;
      m_sd = 1;
    end else if (st0 == 2) begin
      m_st = 0;
      m_q.delete();
      m_lastff = 0;
    end
    m_bv = emit;
    if (emit) begin
      m_bo = b[7:0];
      m_lastff = (b == 255);
    end
    m_af = (m_q.size() >= 64);
  endfunction

  task automatic apply(input bit dr, input logic [31:0] dout, input int dsz, input bit eos);
    dataReady = dr; dataOut = dout; dataSize = 6'(dsz); endOfDataStream = eos;
  endtask

  // One clock edge; the model sees the same inputs, outputs are compared 1 ns after the edge.
  task automatic tick();
    bit          dr  = dataReady;
    logic [31:0] d   = dataOut;
    int          sz  = int'(dataSize);
    bit          eos = endOfDataStream;
    @(posedge clk);
    if (!reset) model_reset();
    else model_step(dr, d, sz, eos);
    #1;
    check("byteValid", 32'(byteValid), 32'(m_bv));
    if (m_bv) check("byteOut", 32'(byteOut), 32'(m_bo));
    check("almostFull", 32'(almostFull), 32'(m_af));
    check("overflow", 32'(overflow), 32'(m_ov));
    check("streamDone", 32'(streamDone), 32'(m_sd));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_byteOut"}, 32'(byteOut), 32'h0);
    check({tag, "_byteValid"}, 32'(byteValid), 32'h0);
    check({tag, "_almostFull"}, 32'(almostFull), 32'h0);
    check({tag, "_overflow"}, 32'(overflow), 32'h0);
    check({tag, "_streamDone"}, 32'(streamDone), 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    apply(0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  typedef struct {
    bit          dr;
    logic [31:0] dout;
    int          dsz;
    bit          eos;
    bit          bv;
    logic [7:0]  bo;
    bit          sd;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [7:0] got[$];
    logic [7:0] exp_b[$];
    logic [31:0] codes[4];
    bit seen_done;

    // Inputs: single byte; stuffing; flush padding; trailing 0xFF.
    vecs.push_back('{1, 32'hAB, 8, 0, 0, 8'h00, 0});
    vecs.push_back('{0, 32'h00, 0, 0, 1, 8'hAB, 0});
    vecs.push_back('{0, 32'h00, 0, 0, 0, 8'h00, 0});
    vecs.push_back('{1, 32'hFF, 8, 0, 0, 8'h00, 0});
    vecs.push_back('{1, 32'h55, 7, 0, 1, 8'hFF, 0});
    vecs.push_back('{0, 32'h00, 0, 0, 1, 8'h55, 0});
    vecs.push_back('{0, 32'h00, 0, 0, 0, 8'h00, 0});
    vecs.push_back('{1, 32'h5, 3, 0, 0, 8'h00, 0});
    vecs.push_back('{1, 32'h5, 3, 0, 0, 8'h00, 0});
    vecs.push_back('{1, 32'h5, 3, 0, 0, 8'h00, 0});
    vecs.push_back('{1, 32'h5, 3, 1, 1, 8'hB6, 0});
    vecs.push_back('{0, 32'h0, 0, 0, 1, 8'hD0, 0});
    vecs.push_back('{0, 32'h0, 0, 0, 0, 8'h00, 1});
    vecs.push_back('{0, 32'h0, 0, 0, 0, 8'h00, 0});
    vecs.push_back('{1, 32'hFF, 8, 1, 0, 8'h00, 0});
    vecs.push_back('{0, 32'h0, 0, 0, 1, 8'hFF, 0});
    vecs.push_back('{0, 32'h0, 0, 0, 1, 8'h00, 0});
    vecs.push_back('{0, 32'h0, 0, 0, 0, 8'h00, 1});
    vecs.push_back('{0, 32'h0, 0, 0, 0, 8'h00, 0});

    // Reset with random inputs toggling: all outputs held at zero.
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      apply(1'($urandom), $urandom, int'($urandom_range(0, 40)), 1'($urandom));
      @(posedge clk);
      #1 check_all_zero("reset");
    end
    apply(0, 0, 0, 0);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) tick();

    // Directed table.
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].dr, vecs[i].dout, vecs[i].dsz, vecs[i].eos);
      tick();
      check($sformatf("vec%0d_byteValid", i), 32'(byteValid), 32'(vecs[i].bv));
      if (vecs[i].bv) check($sformatf("vec%0d_byteOut", i), 32'(byteOut), 32'(vecs[i].bo));
      check($sformatf("vec%0d_streamDone", i), 32'(streamDone), 32'(vecs[i].sd));
    end
    apply(0, 0, 0, 0);

    // Reset in the middle of a flush: no bytes and no streamDone afterwards.
    do_reset();
    apply(1, 32'hA5, 8, 0); tick();
    tick();
    apply(1, 32'hA5, 8, 1); tick();
    apply(0, 0, 0, 0); tick();
    reset = 1'b0;
    #1 check_all_zero("midflush_reset");
    for (int i = 0; i < 3; i++) tick();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_reset_byteValid", 32'(byteValid), 32'h0);
      check("post_reset_streamDone", 32'(streamDone), 32'h0);
    end

    // Overflow: four 32-bit codes back to back; the fourth is dropped.
    do_reset();
    codes = '{32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 32'hDEADBEEF};
    for (int c = 0; c < 3; c++)
      for (int k = 3; k >= 0; k--) exp_b.push_back(8'(codes[c] >> (8 * k)));
    for (int e = 1; e <= 4; e++) begin
      apply(1, codes[e-1], 32, 0);
      tick();
      if (byteValid) got.push_back(byteOut);
      if (e == 2) check("ovf_afull_edge2", 32'(almostFull), 32'h0);
      if (e == 3) begin
        check("ovf_afull_edge3", 32'(almostFull), 32'h1);
        check("ovf_flag_edge3", 32'(overflow), 32'h0);
      end
      if (e == 4) check("ovf_flag_edge4", 32'(overflow), 32'h1);
    end
    apply(0, 0, 0, 1); tick();
    if (byteValid) got.push_back(byteOut);
    apply(0, 0, 0, 0);
    seen_done = 0;
    for (int i = 0; i < 40 && !seen_done; i++) begin
      tick();
      if (byteValid) got.push_back(byteOut);
      if (streamDone) seen_done = 1;
    end
    check("ovf_streamDone_seen", 32'(seen_done), 32'h1);
    check("ovf_byte_count", 32'(got.size()), 32'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < got.size(); i++)
      check($sformatf("ovf_byte%0d", i), 32'(got[i]), 32'(exp_b[i]));
    tick();
    check("ovf_sticky", 32'(overflow), 32'h1);

    // Randomized run against the model, with occasional end-of-stream and async resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] d;
      d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      apply($urandom_range(0, 9) < 4, d, int'($urandom_range(0, 40)),
            $urandom_range(0, 149) == 0);
      if ($urandom_range(0, 999) == 0) begin
        reset = 1'b0;
        #1 check_all_zero("rand_reset");
        tick();
        reset = 1'b1;
      end
      tick();
    end
    apply(0, 0, 0, 0);
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stage8_byte_packer.md
STAGE8_BYTE_PACKER -- requirements
Module: stage8_byte_packer

Interface
REQ-001 Parameter dataOut_length, default 32: width of the code field from the upstream output register stage.
REQ-002 Parameter encodedlength_width, default 6: width of the code-length field.
REQ-003 Parameter acc_width, default 96: bit-accumulator capacity.
REQ-004 clk  input  1  single clock for all state; rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 dataOut  input  dataOut_length  code bits, right-aligned; bit [dataSize-1] is transmitted first.
REQ-007 dataSize  input  encodedlength_width  number of valid code bits, 0..dataOut_length.
REQ-008 dataReady  input  1  code valid this cycle.
REQ-009 endOfDataStream  input  1  level; last code has been presented.
REQ-010 byteOut  output  8  packed JPEG-LS bitstream byte.
REQ-011 byteValid  output  1  byteOut valid this cycle; no backpressure.
REQ-012 almostFull  output  1  accumulator occupancy >= acc_width-32.
REQ-013 overflow  output  1  sticky error flag: input bits were dropped.
REQ-014 streamDone  output  1  one-cycle pulse after the final byte.

Function
REQ-015 The block SHALL keep a bit accumulator with an occupancy counter (0..acc_width) and a lastFF flag that is set when the most recently emitted byte was 0xFF.
REQ-016 States SHALL be RUN, FLUSH and DONE, with RUN as the reset state.
REQ-017 In RUN, when dataReady=1, the block SHALL append dataSize bits, MSB first, at the edge; a dataSize value greater than dataOut_length SHALL be clamped to dataOut_length.
REQ-018 At most one byte SHALL be emitted per edge. The need count is 7 if lastFF=1, else 8.
REQ-019 If occupancy (pre-edge) >= need, the block SHALL register byteOut = {1'b0, 7 bits} when lastFF=1, else the next 8 bits, and set byteValid=1. Otherwise byteValid=0.
REQ-020 Removal and append on the same edge SHALL both apply; new occupancy = occupancy - removed + appended.
REQ-021 If the new occupancy would exceed acc_width, the entire input code SHALL be dropped, overflow set to 1, and the removal SHALL still occur.
REQ-022 Latency: a code appended at edge k SHALL be eligible for output at edge k+1.
REQ-023 RUN->FLUSH SHALL occur at an edge with endOfDataStream=1; a code presented on that same edge SHALL be appended first.
REQ-024 In FLUSH, dataReady and dataOut SHALL be ignored, and whole bytes SHALL drain per REQ-018/019.
REQ-025 In FLUSH, when 0 < occupancy < need, the block SHALL emit the remaining bits MSB-aligned and zero-padded to fill the byte (after the 0 stuff bit if lastFF=1).
REQ-026 In FLUSH, when occupancy=0 and lastFF=1, the block SHALL emit 0x00.
REQ-027 FLUSH->DONE SHALL occur when occupancy=0, lastFF=0, and no byte is emitted that edge.
REQ-028 In DONE, streamDone=1 for exactly one cycle, after which the block returns to RUN with occupancy=0 and lastFF=0; overflow is retained.
REQ-029 almostFull SHALL be registered from the post-edge occupancy.

Reset
REQ-030 While reset=0, asynchronously: byteOut=0x00, byteValid=0, almostFull=0, overflow=0, streamDone=0, occupancy=0, lastFF=0, state=RUN.
REQ-031 Assertion of reset mid-FLUSH or mid-code SHALL discard all buffered bits; no byte and no streamDone pulse SHALL follow.
REQ-032 overflow SHALL be cleared only by reset.

Verification
REQ-033 Reset test: assert reset=0 with random inputs -> all outputs 0; after release with no input, byteValid stays 0.
REQ-034 Single byte: dataOut=0xAB, dataSize=8, dataReady pulsed for 1 cycle -> byteOut=0xAB, byteValid=1 exactly 2 edges later, for 1 cycle.
REQ-035 Stuffing: 0xFF/8 followed by 0x55/7 -> bytes 0xFF then 0x55.
REQ-036 Flush padding: four codes 3'b101/3 on consecutive cycles, endOfDataStream=1 with the last code -> bytes 0xB6, 0xD0, then a streamDone pulse.
REQ-037 Trailing 0xFF: 0xFF/8 presented together with endOfDataStream=1 -> bytes 0xFF, 0x00, then streamDone.
REQ-038 Overflow: dataSize=32, dataReady=1 held for 4 cycles -> almostFull=1 after edge 3; overflow=1 after edge 4 with occupancy 72; the emitted bytes match the first three codes exactly.
